// File: rtl/regfile_wr_arbiter_pkg.sv
// rtl/regfile_wr_arbiter_pkg.sv - shared widths and state encoding for the register file write path
package regfile_wr_arbiter_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

  // CLEAR zero-fills the register file, ARB arbitrates the two writeback ports
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_e;

  // Round-robin priority pointer: which requester wins a tie
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// rtl/regfile_wr_arbiter_rr_arb2.sv - two-requester round-robin grant, one-hot output
module rr_arb2
  import regfile_wr_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  // A lone request always wins; a tie goes to the requester the pointer names
  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      grant_o = (ptr_i == PTR_B) ? 2'b10 : 2'b01;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - zero-fill sequencer and round-robin writeback arbiter for the register file
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clear_req,
  output logic              busy,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data
);

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  ptr_e              ptr_q, ptr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              arb_en;
  logic [1:0]        req;
  logic [1:0]        grant;

  // Requests only reach the arbiter in ARB and when no clear is being requested
  always_comb begin
    arb_en = (state_q == ST_ARB) && !clear_req;
    req    = {b_valid, a_valid} & {2{arb_en}};
  end

  rr_arb2 u_rr_arb2 (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign a_ready        = grant[0];
  assign b_ready        = grant[1];
  assign busy           = (state_q == ST_CLEAR);
  assign reg_write_en   = we_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;

  // Next state: walk the clear counter, or register the granted write and flip priority
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    we_d      = 1'b0;
    dest_d    = dest_q;
    data_d    = data_q;
    case (state_q)
      ST_CLEAR: begin
        we_d      = 1'b1;
        dest_d    = clr_cnt_q;
        data_d    = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (grant[0]) begin
          we_d   = 1'b1;
          dest_d = a_dest;
          data_d = a_data;
          ptr_d  = PTR_B;
        end else if (grant[1]) begin
          we_d   = 1'b1;
          dest_d = b_dest;
          data_d = b_data;
          ptr_d  = PTR_A;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // State and registered write-port drive; reset restarts the full zero-fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= PTR_A;
      clr_cnt_q <= '0;
      we_q      <= 1'b0;
      dest_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      clr_cnt_q <= clr_cnt_d;
      we_q      <= we_d;
      dest_q    <= dest_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, clear_req;
  logic [2:0]  a_dest, b_dest;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, busy;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;

  logic [15:0] shadow [8];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .a_valid        (a_valid),
    .a_dest         (a_dest),
    .a_data         (a_data),
    .a_ready        (a_ready),
    .b_valid        (b_valid),
    .b_dest         (b_dest),
    .b_data         (b_data),
    .b_ready        (b_ready),
    .clear_req      (clear_req),
    .busy           (busy),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and mirror any register file write
  task automatic tick();
    @(posedge clk);
    #1;
    if (reg_write_en === 1'b1) shadow[reg_write_dest] = reg_write_data;
  endtask

  task automatic check_write(input string tag, input logic en, input logic [2:0] dest, input logic [15:0] data);
    check_eq({tag, "_en"}, 32'(reg_write_en), 32'(en));
    if (en) begin
      check_eq({tag, "_dest"}, 32'(reg_write_dest), 32'(dest));
      check_eq({tag, "_data"}, 32'(reg_write_data), 32'(data));
    end
  endtask

  // Caller is just past the edge that left the block in CLEAR
  task automatic clear_seq(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_a_ready"}, 32'(a_ready), 32'd0);
      check_eq({tag, "_b_ready"}, 32'(b_ready), 32'd0);
      tick();
      check_write(tag, 1'b1, 3'(i), 16'h0000);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) shadow[i] = 16'hFFFF;
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; clear_req = 1'b0;
    a_dest = 3'd0; b_dest = 3'd0; a_data = 16'h0; b_data = 16'h0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_a_ready", 32'(a_ready), 32'd0);
    check_eq("rst_b_ready", 32'(b_ready), 32'd0);
    check_write("rst_wr", 1'b0, 3'd0, 16'h0);
    check_eq("rst_dest", 32'(reg_write_dest), 32'd0);
    check_eq("rst_data", 32'(reg_write_data), 32'd0);
    tick(); tick();
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
    #1;

    // Full zero-fill after reset release
    clear_seq("init_clr", 8);
    check_eq("init_busy_done", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) check_eq("init_shadow_zero", 32'(shadow[i]), 32'd0);

    // Lone A request
    a_valid = 1'b1; a_dest = 3'd3; a_data = 16'h1234;
    #1;
    check_eq("solo_a_ready", 32'(a_ready), 32'd1);
    check_eq("solo_a_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    check_write("solo_a_wr", 1'b1, 3'd3, 16'h1234);
    tick();
    check_write("idle_wr", 1'b0, 3'd0, 16'h0);

    // Lone B request returns the pointer to A
    b_valid = 1'b1; b_dest = 3'd1; b_data = 16'h0001;
    #1;
    check_eq("solo_b_ready", 32'(b_ready), 32'd1);
    check_eq("solo_b_a_ready", 32'(a_ready), 32'd0);
    tick();
    b_valid = 1'b0;
    check_write("solo_b_wr", 1'b1, 3'd1, 16'h0001);

    // Both pending for four cycles: A, B, A, B
    a_valid = 1'b1; a_dest = 3'd2; a_data = 16'hA002;
    b_valid = 1'b1; b_dest = 3'd4; b_data = 16'hB004;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("rr_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      if (i % 2 == 0) check_write("rr_wr", 1'b1, 3'd2, 16'hA002);
      else            check_write("rr_wr", 1'b1, 3'd4, 16'hB004);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check_write("rr_idle_wr", 1'b0, 3'd0, 16'h0);

    // Same destination from both: later grant persists
    a_valid = 1'b1; a_dest = 3'd5; a_data = 16'hAAAA;
    b_valid = 1'b1; b_dest = 3'd5; b_data = 16'hBBBB;
    #1;
    check_eq("same_a_ready", 32'(a_ready), 32'd1);
    check_eq("same_b_wait", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    check_write("same_wr1", 1'b1, 3'd5, 16'hAAAA);
    #1;
    check_eq("same_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check_write("same_wr2", 1'b1, 3'd5, 16'hBBBB);
    check_eq("same_reg5", 32'(shadow[5]), 32'hBBBB);

    // Clear request blocks a pending A, then A wins on first ARB cycle
    a_valid = 1'b1; a_dest = 3'd6; a_data = 16'h6666; clear_req = 1'b1;
    #1;
    check_eq("clr_a_ready", 32'(a_ready), 32'd0);
    check_eq("clr_busy_pre", 32'(busy), 32'd0);
    tick();
    clear_req = 1'b0;
    check_write("clr_no_wr", 1'b0, 3'd0, 16'h0);
    clear_seq("req_clr", 8);
    check_eq("req_clr_busy_done", 32'(busy), 32'd0);
    check_eq("req_clr_reg5", 32'(shadow[5]), 32'd0);
    check_eq("post_clr_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    check_write("post_clr_wr", 1'b1, 3'd6, 16'h6666);

    // Reset after the fourth clear write restarts the full sequence
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    clear_seq("part_clr", 4);
    #2;
    rst = 1'b1;
    #1;
    check_write("midrst_wr", 1'b0, 3'd0, 16'h0);
    check_eq("midrst_dest", 32'(reg_write_dest), 32'd0);
    check_eq("midrst_data", 32'(reg_write_data), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    clear_seq("rst_clr", 8);
    check_eq("rst_clr_busy_done", 32'(busy), 32'd0);

    // Pointer back to A after reset
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check_eq("rst_ptr_a_ready", 32'(a_ready), 32'd1);
    check_eq("rst_ptr_b_ready", 32'(b_ready), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
